// File: rtl/counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types for the counter command sequencer.
//   CNT_WIDTH : default counter width (data/count width of the 12-bit counter)
//   op_e      : command opcodes carried on req_op
//   state_e   : sequencer FSM states
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int CNT_WIDTH = 12;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_SEEK = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_SEEK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// NREQ-wide round-robin arbiter. The search starts at the pointer and wraps;
// the first requester found is granted. When a grant is given while enabled
// it is accepted in the same cycle, and the pointer moves to the requester
// just after the winner.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> 0)
//   i_enable     : arbitration allowed this cycle (sequencer idle)
//   i_req        : per-requester valid
//   o_grant      : one-hot grant (all zero when disabled or no request)
//   o_grant_id   : index of the granted requester
//   o_any        : a grant is being given this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_enable,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_any
);

    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_found;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NREQ;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && i_req[wrap_idx(int'(r_ptr), off)]) begin
                w_found    = 1'b1;
                w_grant[wrap_idx(int'(r_ptr), off)] = 1'b1;
                w_grant_id = IDW'(wrap_idx(int'(r_ptr), off));
            end
        end
        if (!i_enable) begin
            w_grant = '0;
            w_found = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    assign o_grant    = w_grant;
    assign o_grant_id = w_grant_id;
    assign o_any      = w_found;

endmodule

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
// Owns the control pins of an up/down counter with parallel load. Accepts
// LOAD / UP / DOWN / SEEK commands from NREQ requesters (round-robin) and
// executes one at a time, then pulses done with the final count.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is combinational)
//   req_op, req_arg       : per-requester opcode and argument, packed by index
//   cnt_enable/cnt_load/cnt_up_down/cnt_data : registered counter controls
//   cnt_count             : current counter value
//   busy                  : command in flight (cycle after accept .. DONE)
//   done, done_id         : one-cycle completion pulse and requester id
//   result                : count sampled in the DONE cycle, held
// All outputs except req_ready are registered: the control values for the
// next cycle are computed from the next state and loaded at the clock edge.
// ---------------------------------------------------------------------------
module counter_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int NREQ  = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_arg,
    output logic                  cnt_enable,
    output logic                  cnt_load,
    output logic                  cnt_up_down,
    output logic [WIDTH-1:0]      cnt_data,
    input  logic [WIDTH-1:0]      cnt_count,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result
);

    state_e           r_state;
    logic [WIDTH-1:0] r_arg;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_remaining;
    logic             r_cnt_enable;
    logic             r_cnt_load;
    logic             r_cnt_up_down;
    logic [WIDTH-1:0] r_cnt_data;
    logic             r_busy;
    logic             r_done;
    logic [IDW-1:0]   r_done_id;
    logic [WIDTH-1:0] r_result;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_grant_id;
    logic             w_accept;
    op_e              w_acc_op;
    logic [WIDTH-1:0] w_acc_arg;
    logic [IDW-1:0]   w_cur_id;
    logic [WIDTH-1:0] w_seek_next;

    state_e           w_next_state;
    logic             w_nx_enable;
    logic             w_nx_load;
    logic             w_nx_up_down;
    logic [WIDTH-1:0] w_nx_data;
    logic [WIDTH-1:0] w_nx_remaining;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (r_state == ST_IDLE),
        .i_req     (req_valid),
        .o_grant   (w_grant),
        .o_grant_id(w_grant_id),
        .o_any     (w_accept)
    );

    assign req_ready = w_grant;
    assign w_acc_op  = op_e'(req_op[2*int'(w_grant_id) +: 2]);
    assign w_acc_arg = req_arg[WIDTH*int'(w_grant_id) +: WIDTH];

    // A command may complete straight from IDLE (zero steps / already at
    // target), before r_id has been written, so take the live grant id there.
    assign w_cur_id = (r_state == ST_IDLE) ? w_grant_id : r_id;

    // Enable is always high while seeking, so the count seen next cycle is
    // one step further. Deciding on that value lets the registered enable
    // drop exactly when the counter lands on the target.
    assign w_seek_next = r_cnt_up_down ? cnt_count + WIDTH'(1) : cnt_count - WIDTH'(1);

    always_comb begin
        w_next_state   = r_state;
        w_nx_enable    = 1'b0;
        w_nx_load      = 1'b0;
        w_nx_up_down   = r_cnt_up_down;
        w_nx_data      = r_cnt_data;
        w_nx_remaining = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_acc_op)
                        OP_LOAD: begin
                            w_next_state = ST_LOAD;
                            w_nx_enable  = 1'b1;
                            w_nx_load    = 1'b1;
                            w_nx_data    = w_acc_arg;
                        end
                        OP_UP, OP_DOWN: begin
                            if (w_acc_arg == '0) begin
                                w_next_state = ST_DONE;
                            end else begin
                                w_next_state   = ST_STEP;
                                w_nx_enable    = 1'b1;
                                w_nx_up_down   = (w_acc_op == OP_UP);
                                w_nx_remaining = w_acc_arg;
                            end
                        end
                        OP_SEEK: begin
                            if (cnt_count == w_acc_arg) begin
                                w_next_state = ST_DONE;
                            end else begin
                                w_next_state = ST_SEEK;
                                w_nx_enable  = 1'b1;
                                w_nx_up_down = (w_acc_arg > cnt_count);
                            end
                        end
                        default: w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: w_next_state = ST_DONE;
            ST_STEP: begin
                // remaining counts the enable cycles still including this one
                if (r_remaining == WIDTH'(1)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_nx_enable    = 1'b1;
                    w_nx_remaining = r_remaining - WIDTH'(1);
                end
            end
            ST_SEEK: begin
                if (w_seek_next == r_arg) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_nx_enable  = 1'b1;
                    w_nx_up_down = (r_arg > w_seek_next);
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_arg         <= '0;
            r_id          <= '0;
            r_remaining   <= '0;
            r_cnt_enable  <= 1'b0;
            r_cnt_load    <= 1'b0;
            r_cnt_up_down <= 1'b0;
            r_cnt_data    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_done_id     <= '0;
            r_result      <= '0;
        end else begin
            r_state       <= w_next_state;
            r_remaining   <= w_nx_remaining;
            r_cnt_enable  <= w_nx_enable;
            r_cnt_load    <= w_nx_load;
            r_cnt_up_down <= w_nx_up_down;
            r_cnt_data    <= w_nx_data;
            r_busy        <= (w_next_state != ST_IDLE);
            r_done        <= (w_next_state == ST_DONE);
            if (w_accept) begin
                r_arg <= w_acc_arg;
                r_id  <= w_grant_id;
            end
            if (w_next_state == ST_DONE) begin
                r_done_id <= w_cur_id;
            end
            if (r_state == ST_DONE) begin
                r_result <= cnt_count;
            end
        end
    end

    assign cnt_enable  = r_cnt_enable;
    assign cnt_load    = r_cnt_load;
    assign cnt_up_down = r_cnt_up_down;
    assign cnt_data    = r_cnt_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_id     = r_done_id;
    assign result      = r_result;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command sequencer that owns the control inputs of the 12-bit up/down counter with parallel load. It accepts LOAD, STEP-UP, STEP-DOWN and SEEK commands from NREQ requesters over valid/ready handshakes, arbitrates between them round-robin, and drives the counter's enable/load/up_down/data pins one command at a time. On completion it reports the final count and the requester id.

## Interface
- WIDTH, 12, counter width; matches the counter's data/count width.
- NREQ, 2, number of requesters (2..8).
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_op  input  2*NREQ  per-requester opcode: 00 LOAD, 01 UP, 10 DOWN, 11 SEEK.
- req_arg  input  WIDTH*NREQ  per-requester argument: load value, step count, or seek target.
- cnt_enable  output  1  to counter enable.
- cnt_load  output  1  to counter load.
- cnt_up_down  output  1  to counter up_down (1 = up).
- cnt_data  output  WIDTH  to counter data.
- cnt_count  input  WIDTH  from counter count.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- done_id  output  $clog2(NREQ)  requester whose command completed; valid with done.
- result  output  WIDTH  cnt_count sampled in the DONE cycle; held until the next done.

## Operation
- States: IDLE, LOAD, STEP, SEEK, DONE.
- IDLE: the arbiter picks the first requester with valid set, starting at rr_ptr and wrapping. Only that requester's req_ready is high, combinationally. On valid&ready, latch op, arg and id; rr_ptr <= (id+1) mod NREQ.
- Accepting LOAD goes to LOAD, UP/DOWN to STEP with remaining = arg, and SEEK to SEEK.
- LOAD: one cycle with cnt_enable=1, cnt_load=1, cnt_data=arg. Next state is DONE.
- STEP: cnt_enable=1, cnt_up_down=(op==UP) for exactly arg cycles; remaining decrements each cycle. DONE follows when remaining reaches 0. arg=0 goes from IDLE straight to DONE with no enable cycle.
- SEEK: each cycle compare cnt_count with target.
  - Equal: cnt_enable=0 and go to DONE.
  - Otherwise: cnt_enable=1 and cnt_up_down=(target>cnt_count), unsigned.
  - Moves at most 2^WIDTH-1 cycles; no wrap is used.
- DONE: done=1, done_id=id, result<=cnt_count. Next state is IDLE, and a new accept is possible on the following cycle.
- cnt_load is 0 outside LOAD. cnt_data holds the last load value.
- Counter arithmetic is modulo 2^WIDTH. UP from 4095 wraps to 0, DOWN from 0 wraps to 4095; the sequencer does not saturate.
- Requests arriving while not IDLE see req_ready=0. Requesters must hold valid and payload stable until accepted.
- Reset (any time, including mid-command) gives state IDLE and rr_ptr=0. All outputs go to 0: req_ready, cnt_*, busy, done, done_id, result. An aborted command produces no done.

## Timing
- Accept at cycle 0.
- LOAD: cnt_load high in cycle 1, done in cycle 2.
- UP/DOWN N (N≥1): enable high in cycles 1..N, done in cycle N+1. N=0: done in cycle 1.
- SEEK distance D: enable high for D cycles starting cycle 1, done in cycle D+1. D=0: done in cycle 1.
- Back-to-back throughput: LOAD command every 3 cycles.
- All outputs except req_ready are registered. req_ready depends combinationally only on state, rr_ptr and req_valid.

## Structure
- Package counter_ctrl_pkg: op_e (LOAD/UP/DOWN/SEEK), state_e, WIDTH default constant.
- Sub-module rr_arbiter (NREQ-wide round-robin with grant-accept pointer update) is instantiated once. The FSM and step/seek datapath stay in counter_sequencer.

## Test plan
- Reset then requester 0 LOAD 0x5A5 -> cnt_load high for 1 cycle with cnt_data=0x5A5; done in cycle 2, done_id=0, result=0x5A5.
- LOAD 0x0FFE, then UP 3 -> 3 enable cycles with up_down=1; result=0x001 (wrap through 0xFFF, 0x000).
- Both requesters valid continuously with LOAD 0x100 and LOAD 0x200 -> grants alternate 0,1,0,1; results alternate 0x100/0x200.
- LOAD 0x010, then SEEK 0x00C -> 4 enable cycles with up_down=0; result=0x00C. A following SEEK 0x00C completes in cycle 1 with no enable.
- UP 0 -> done in cycle 1 with cnt_enable never high; result unchanged.
- DOWN 100 with reset_n asserted at step 40 -> all outputs 0 immediately, no done pulse; next accept goes to requester 0.
